// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and sizing helper for the debounce/edge detector
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHK_HIGH,
        STABLE_HIGH,
        CHK_LOW
    } dbnc_state_e;

    // Width of the stability counter; never narrower than one bit.
    function automatic int stab_cnt_width(input int stable_cycles);
        return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - saturating event counter with sticky overflow flag
module sat_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Clear is applied first so a coincident increment lands on a fresh count of one.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
        if (inc) begin
            if (count_d == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - debounces a synchronised bit, emits rise/fall pulses and counts rises
module sync_debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             a,
    input  logic             clr_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_ovf
);

    localparam int            SC_W     = stab_cnt_width(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

    dbnc_state_e     state_q, state_d;
    logic [SC_W-1:0] stab_cnt_q, stab_cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    // The sample that leaves a stable state counts as the first of the run.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                if (a) begin
                    state_d    = CHK_HIGH;
                    stab_cnt_d = SC_ONE;
                end
            end
            CHK_HIGH: begin
                if (!a) begin
                    state_d    = STABLE_LOW;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == SC_LAST) begin
                    state_d    = STABLE_HIGH;
                    stab_cnt_d = '0;
                    level_d    = 1'b1;
                    rise_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + SC_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!a) begin
                    state_d    = CHK_LOW;
                    stab_cnt_d = SC_ONE;
                end
            end
            CHK_LOW: begin
                if (a) begin
                    state_d    = STABLE_HIGH;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == SC_LAST) begin
                    state_d    = STABLE_LOW;
                    stab_cnt_d = '0;
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + SC_ONE;
                end
            end
            default: begin
                state_d    = STABLE_LOW;
                stab_cnt_d = '0;
                level_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= STABLE_LOW;
            stab_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // Counts the visible rise pulse, so a clear asserted alongside it yields a count of one.
    sat_event_counter #(
        .CNT_W (CNT_W)
    ) u_rise_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (rise_q),
        .clr   (clr_cnt),
        .count (edge_cnt),
        .ovf   (cnt_ovf)
    );

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb/tb_sync_debounce_edge.sv - table-driven and directed checks for sync_debounce_edge
module tb_sync_debounce_edge;

    logic       clk;
    logic       rstn;
    logic       a;
    logic       clr_cnt;
    logic       level;
    logic       rise;
    logic       fall;
    logic [3:0] edge_cnt;
    logic       cnt_ovf;

    int checks = 0;
    int errors = 0;

    sync_debounce_edge #(
        .STABLE_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .a        (a),
        .clr_cnt  (clr_cnt),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt),
        .cnt_ovf  (cnt_ovf)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       clr;
        logic       lvl;
        logic       rs;
        logic       fl;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic ai, input logic ci, input logic l, input logic r,
                                input logic f, input logic [3:0] n, input logic o);
        vec_t v;
        v.a = ai; v.clr = ci; v.lvl = l; v.rs = r; v.fl = f; v.cnt = n; v.ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(output int rises);
        rises = 0;
        for (int k = 0; k < 4; k++) begin
            a = 1'b1;
            step();
            rises += int'(rise);
        end
        for (int k = 0; k < 4; k++) begin
            a = 1'b0;
            step();
            rises += int'(rise);
        end
    endtask

    initial begin
        int rise_total;
        int r;
        int first_rise;
        int rise_seen;
        int fall_seen;
        int lvl_changes;

        // row: a, clr -> level, rise, fall, edge_cnt, cnt_ovf
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 1, 1, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 0, 1, 0);
        vecs[6]  = mk(1, 0, 1, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0);
        vecs[12] = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[13] = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[14] = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 0);
        vecs[17] = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0);

        rstn    = 1'b0;
        a       = 1'b0;
        clr_cnt = 1'b0;
        #2;
        check("reset_level", int'(level), 0);
        check("reset_rise", int'(rise), 0);
        check("reset_fall", int'(fall), 0);
        check("reset_cnt", int'(edge_cnt), 0);
        check("reset_ovf", int'(cnt_ovf), 0);
        #3;
        rstn = 1'b1;

        // Clean step, falling step, 3-cycle glitch, counter clear.
        for (int i = 0; i < 19; i++) begin
            a       = vecs[i].a;
            clr_cnt = vecs[i].clr;
            step();
            check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].lvl));
            check($sformatf("vec%0d_rise", i), int'(rise), int'(vecs[i].rs));
            check($sformatf("vec%0d_fall", i), int'(fall), int'(vecs[i].fl));
            check($sformatf("vec%0d_cnt", i), int'(edge_cnt), int'(vecs[i].cnt));
            check($sformatf("vec%0d_ovf", i), int'(cnt_ovf), int'(vecs[i].ovf));
        end
        clr_cnt = 1'b0;

        // Saturation: 15 pulses fill the counter, the 16th sets overflow.
        rise_total = 0;
        for (int p = 0; p < 15; p++) begin
            pulse(r);
            rise_total += r;
        end
        check("sat15_cnt", int'(edge_cnt), 15);
        check("sat15_ovf", int'(cnt_ovf), 0);
        pulse(r);
        rise_total += r;
        check("sat16_rises", rise_total, 16);
        check("sat16_cnt", int'(edge_cnt), 15);
        check("sat16_ovf", int'(cnt_ovf), 1);

        // Clear coincident with a rise pulse.
        for (int k = 0; k < 4; k++) begin
            a = 1'b1;
            step();
        end
        check("clr_rise_pulse", int'(rise), 1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_rise_cnt", int'(edge_cnt), 1);
        check("clr_rise_ovf", int'(cnt_ovf), 0);

        // Reset in the middle of a high check.
        for (int k = 0; k < 5; k++) begin
            a = 1'b0;
            step();
        end
        check("pre_rst_level", int'(level), 0);
        a = 1'b1;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_level", int'(level), 0);
        check("midrst_rise", int'(rise), 0);
        check("midrst_fall", int'(fall), 0);
        check("midrst_cnt", int'(edge_cnt), 0);
        check("midrst_ovf", int'(cnt_ovf), 0);
        @(negedge clk);
        rstn = 1'b1;
        first_rise = 0;
        rise_seen  = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (rise && first_rise == 0) first_rise = n;
            rise_seen += int'(rise);
        end
        check("postrst_rise_edge", first_rise, 4);
        check("postrst_rise_count", rise_seen, 1);
        check("postrst_level", int'(level), 1);
        check("postrst_cnt", int'(edge_cnt), 1);

        // Bouncing input must never be accepted.
        rise_seen   = 0;
        fall_seen   = 0;
        lvl_changes = 0;
        for (int i = 0; i < 20; i++) begin
            a = (i % 2 == 1);
            step();
            rise_seen += int'(rise);
            fall_seen += int'(fall);
            if (level !== 1'b1) lvl_changes++;
        end
        check("bounce_rise", rise_seen, 0);
        check("bounce_fall", fall_seen, 0);
        check("bounce_level", lvl_changes, 0);
        check("bounce_cnt", int'(edge_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
